fft_sample_fetch: RTL and testbench

Downstream consumer of the FFT address calculator. It accepts the address stream, issues one memory read per address, and buffers the returned words in a FIFO. Samples go out to the FFT core over a valid/ready handshake. It owns the calculator's `pause` input, throttling address generation so the buffer never overflows, and it marks the final sample of each transfer.

---
 rtl/fft_sample_fetch.sv | 146 ++++++++++++++
 tb/tb_fft_sample_fetch.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sample_fetch.sv
// Fetches one memory word per calculator address and streams the words to the FFT core.
// Address generation is throttled through a registered pause so the sample FIFO never overflows.
`timescale 1ns/1ps
module fft_sample_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              addr_valid,
  input  logic              addr_done,
  output logic              pause,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              sample_last,
  output logic              xfer_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              pause_q, pause_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [31:0]       acc_cnt_q, acc_cnt_d;
  logic [31:0]       out_cnt_q, out_cnt_d;
  logic              done_seen_q, done_seen_d;
  logic [DATA_W-1:0] fifo_mem [DEPTH];

  logic accept;
  logic push;
  logic pop;

  assign sample_valid = (cnt_q != '0);
  assign pop          = sample_valid & sample_ready;
  assign accept       = addr_valid & ~pause_q & ((state_q == S_IDLE) | (state_q == S_FETCH));
  // Responses arriving with nothing in flight are leftovers from before a reset.
  assign push         = mem_rvalid & (inflight_q != '0);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    done_seen_d = done_seen_q;
    inflight_d  = inflight_q + CW'(accept) - CW'(push);
    outst_d     = outst_q + CW'(accept) - CW'(pop);
    cnt_d       = cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    acc_cnt_d   = acc_cnt_q + 32'(accept);
    out_cnt_d   = out_cnt_q + 32'(pop);
    rd_en_d     = accept;
    mem_addr_d  = accept ? addr_in : mem_addr_q;

    case (state_q)
      S_IDLE: begin
        if (accept && addr_done) begin
          state_d     = S_DRAIN;
          done_seen_d = 1'b1;
        end else if (accept) begin
          state_d = S_FETCH;
        end else if (addr_done) begin
          state_d = S_DONE;
        end
      end
      S_FETCH: begin
        if (addr_done) begin
          state_d     = S_DRAIN;
          done_seen_d = 1'b1;
        end
      end
      S_DRAIN: begin
        // Looking at next-cycle occupancy lets xfer_done follow the last handshake directly.
        if (inflight_d == '0 && cnt_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        state_d     = S_IDLE;
        done_seen_d = 1'b0;
        acc_cnt_d   = '0;
        out_cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    pause_d = (outst_d >= CW'(DEPTH - 1)) || (state_d == S_DRAIN) || (state_d == S_DONE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pause_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      mem_addr_q  <= '0;
      inflight_q  <= '0;
      outst_q     <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      acc_cnt_q   <= '0;
      out_cnt_q   <= '0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pause_q     <= pause_d;
      rd_en_q     <= rd_en_d;
      mem_addr_q  <= mem_addr_d;
      inflight_q  <= inflight_d;
      outst_q     <= outst_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      acc_cnt_q   <= acc_cnt_d;
      out_cnt_q   <= out_cnt_d;
      done_seen_q <= done_seen_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_rdata;
  end

  assign pause       = pause_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_addr    = mem_addr_q;
  assign xfer_done   = (state_q == S_DONE);
  assign sample_data = sample_valid ? fifo_mem[rd_ptr_q] : '0;
  assign sample_last = sample_valid & done_seen_q & ((out_cnt_q + 32'd1) == acc_cnt_q);

endmodule

// File: tb/tb_fft_sample_fetch.sv
// Scoreboard bench for fft_sample_fetch: accepted addresses queue their expected words,
// a behavioural memory answers reads in order, and a monitor checks every delivered sample.
`timescale 1ns/1ps
module tb_fft_sample_fetch;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] addr_in = '0;
  logic              addr_valid = 1'b0;
  logic              addr_done = 1'b0;
  logic              pause;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_rvalid = 1'b0;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready = 1'b0;
  logic              sample_last;
  logic              xfer_done;

  fft_sample_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .addr_valid(addr_valid), .addr_done(addr_done),
    .pause(pause), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .sample_last(sample_last), .xfer_done(xfer_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  // Reference state
  logic [31:0] exp_q[$];
  bit          done_flag = 1'b0;
  int          exp_xfer_cyc = -1;
  int          xfer_cnt = 0, rd_cnt = 0, valid_cnt = 0, hs_cnt = 0;
  int          backlog = 0, max_backlog = 0;
  int          hs_cyc_log[$];
  int          lat_min = 3, lat_max = 3, ready_pct = 100;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;
  rsp_t rsp_q[$];
  rsp_t rsp_new;
  int   last_due = 0;
  int   due_tmp;

  // In-order memory with per-read latency drawn from [lat_min, lat_max].
  always @(posedge clk) begin
    #1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end
    if (mem_rd_en) begin
      due_tmp = cyc + int'($urandom_range(lat_max, lat_min));
      if (due_tmp <= last_due) due_tmp = last_due + 1;
      last_due     = due_tmp;
      rsp_new.data = mem_word(mem_addr);
      rsp_new.due  = due_tmp;
      rsp_q.push_back(rsp_new);
    end
  end

  always @(posedge clk) begin
    #1;
    sample_ready = (int'($urandom_range(99, 0)) < ready_pct);
  end

  logic [31:0] e_word;
  bit          e_last;

  // Monitor: pops the scoreboard on every handshake and checks xfer_done timing.
  always @(negedge clk) begin
    if (rst) begin
      backlog = 0;
    end else begin
      if (mem_rd_en) begin
        rd_cnt++;
        backlog++;
      end
      if (sample_valid) valid_cnt++;
      if (sample_valid && sample_ready) begin
        hs_cnt++;
        backlog--;
        hs_cyc_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_sample", 1, 0);
        end else begin
          e_last = done_flag && (exp_q.size() == 1);
          e_word = exp_q.pop_front();
          check("sample_data", sample_data, e_word);
          check("sample_last", sample_last, e_last);
          if (e_last) exp_xfer_cyc = cyc + 1;
        end
      end
      if (backlog > max_backlog) max_backlog = backlog;
      if (xfer_done || cyc == exp_xfer_cyc) begin
        check("xfer_done", xfer_done, cyc == exp_xfer_cyc);
        if (xfer_done) xfer_cnt++;
        if (cyc == exp_xfer_cyc) begin
          exp_xfer_cyc = -1;
          done_flag    = 1'b0;
        end
      end
    end
  end

  // Called at posedge+1; holds the address until the DUT takes it.
  task automatic send_addr(input logic [31:0] a, input bit with_done);
    int waited;
    bit acc;
    waited = 0;
    acc = 1'b0;
    addr_valid = 1'b1;
    addr_in    = a;
    while (!acc) begin
      acc       = !pause;
      addr_done = with_done && acc;
      @(posedge clk); #1;
      if (acc) begin
        exp_q.push_back(mem_word(a));
        if (with_done) done_flag = 1'b1;
      end else if (++waited > 3000) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    addr_valid = 1'b0;
    addr_done  = 1'b0;
  endtask

  task automatic send_done();
    addr_done = 1'b1;
    @(posedge clk); #1;
    done_flag = 1'b1;
    addr_done = 1'b0;
  endtask

  task automatic wait_xfer(input int budget);
    int start, n;
    start = xfer_cnt;
    n = 0;
    while (xfer_cnt == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("xfer_seen", xfer_cnt - start, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pause"}, pause, 0);
    check({tag, "_rd_en"}, mem_rd_en, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_valid"}, sample_valid, 0);
    check({tag, "_last"}, sample_last, 0);
    check({tag, "_xfer"}, xfer_done, 0);
    check({tag, "_data"}, sample_data, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, r0, v0, x0, t0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic stream, L=3
    h0 = hs_cnt;
    t0 = cyc;
    for (int i = 0; i < 8; i++) send_addr(32'(i), 1'b0);
    send_done();
    wait_xfer(300);
    check("basic_count", hs_cnt - h0, 8);
    check("basic_latency", hs_cyc_log[h0] - t0, 5);
    check("basic_empty", exp_q.size(), 0);

    // Zero-length transfer
    r0 = rd_cnt; v0 = valid_cnt; x0 = xfer_cnt;
    addr_done    = 1'b1;
    exp_xfer_cyc = cyc + 1;
    @(posedge clk); #1;
    addr_done = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("zero_no_read", rd_cnt - r0, 0);
    check("zero_no_valid", valid_cnt - v0, 0);
    check("zero_xfer", xfer_cnt - x0, 1);

    // Same-cycle done with the 5th address
    h0 = hs_cnt;
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 5; i++) send_addr(32'(32'h40 + i), i == 4);
    wait_xfer(300);
    check("same_cycle_count", hs_cnt - h0, 5);

    // Backpressure
    ready_pct = 0;
    lat_min = 2; lat_max = 2;
    @(posedge clk); #1;
    h0 = hs_cnt; r0 = rd_cnt;
    fork
      begin
        for (int i = 0; i < 40; i++) send_addr(32'(32'h1000 + 4 * i), 1'b0);
        send_done();
      end
      begin
        repeat (40) @(posedge clk);
        #1;
        check("bp_reads", rd_cnt - r0, DEPTH - 1);
        check("bp_pause", pause, 1);
        check("bp_hs_none", hs_cnt - h0, 0);
        ready_pct = 100;
      end
    join
    wait_xfer(2000);
    check("bp_count", hs_cnt - h0, 40);
    check("bp_backlog", max_backlog <= DEPTH, 1);

    // Random stream
    ready_pct = 60;
    lat_min = 1; lat_max = 6;
    h0 = hs_cnt;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        @(posedge clk); #1;
      end
      send_addr($urandom, 1'b0);
    end
    send_done();
    wait_xfer(20000);
    check("rand_count", hs_cnt - h0, 1000);
    check("rand_backlog", max_backlog <= DEPTH, 1);
    check("rand_empty", exp_q.size(), 0);

    // Reset mid-transfer with reads in flight and data buffered
    ready_pct = 0;
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 10; i++) send_addr(32'(32'h2000 + i), 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid");
    exp_q.delete();
    done_flag    = 1'b0;
    exp_xfer_cyc = -1;
    @(posedge clk); #1;
    rst = 1'b0;
    ready_pct = 100;
    due_tmp = (cyc + 2 > last_due) ? cyc + 2 : last_due + 1;
    last_due = due_tmp;
    rsp_new.data = 32'hDEAD_BEEF;
    rsp_new.due  = due_tmp;
    rsp_q.push_back(rsp_new);
    v0 = valid_cnt;
    repeat (15) @(posedge clk);
    #1;
    check("stale_no_sample", valid_cnt - v0, 0);
    check("stale_valid_low", sample_valid, 0);

    // Recovery after reset
    h0 = hs_cnt;
    for (int i = 0; i < 3; i++) send_addr(32'(32'h3000 + i), i == 2);
    wait_xfer(300);
    check("recover_count", hs_cnt - h0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
